// File: rtl/seq_detect_pkg.sv
// Shared definitions for the parametrised serial pattern detector:
// output-timing mode codes and the fill-counter width helper.
package seq_detect_pkg;

  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;

  // Width that holds 0..pat_len-1 valid history bits.
  function automatic int fill_w(input int pat_len);
    return $clog2(pat_len);
  endfunction

endpackage

// File: rtl/seq_detect_param_if.sv
// Serial stream and status bundle of the pattern detector.
// The master drives the stream; the slave (the detector) reports det/det_cnt.
interface seq_detect_param_if #(
  parameter int CNT_W = 8
);
  logic             en;
  logic             din;
  logic             clr;
  logic             det;
  logic [CNT_W-1:0] det_cnt;

  modport master (output en, output din, output clr, input det, input det_cnt);
  modport slave  (input en, input din, input clr, output det, output det_cnt);
endinterface

// File: rtl/seq_detect_param_sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment,
// and the count holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (clr) begin
      cnt_next = '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector: history shift register plus fill
// counter, Mealy or registered Moore detect output, saturating match counter.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1010,
  parameter bit                 OVERLAP = 1'b1,
  parameter int                 MOORE   = MODE_MEALY,
  parameter int                 CNT_W   = 8
) (
  input logic               clk,
  input logic               reset,
  seq_detect_param_if.slave bus
);

  localparam int             FW       = fill_w(PAT_LEN);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_LEN - 1);

  if ((PAT_LEN < 2) || (PAT_LEN > 32)) begin : g_bad_len
    $error("seq_detect_param: PAT_LEN must be within 2..32");
  end

  logic [PAT_LEN-2:0] hist_reg;
  logic [PAT_LEN-2:0] hist_next;
  logic [FW-1:0]      fill_reg;
  logic [FW-1:0]      fill_next;
  logic               match;

  // A two-bit pattern keeps a single history bit, so there is nothing to shift.
  if (PAT_LEN == 2) begin : g_hist_one
    assign hist_next = bus.din;
  end else begin : g_hist_shift
    assign hist_next = {hist_reg[PAT_LEN-3:0], bus.din};
  end

  // State register: history and fill only advance on accepted bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hist_reg <= '0;
      fill_reg <= '0;
    end else if (bus.en) begin
      hist_reg <= hist_next;
      fill_reg <= fill_next;
    end
  end

  // Next-state logic; without overlap a match empties the history.
  always_comb begin
    fill_next = fill_reg;
    if (bus.en) begin
      if (!OVERLAP && match) begin
        fill_next = '0;
      end else if (fill_reg != FILL_MAX) begin
        fill_next = fill_reg + FW'(1);
      end
    end
  end

  // Output logic.
  always_comb begin
    match = bus.en && (fill_reg == FILL_MAX) && ({hist_reg, bus.din} == PATTERN);
  end

  if (MOORE == MODE_MOORE) begin : g_moore
    logic det_reg;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        det_reg <= 1'b0;
      end else begin
        det_reg <= match;
      end
    end

    assign bus.det = det_reg;
  end else begin : g_mealy
    assign bus.det = match;
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (match),
    .clr   (bus.clr),
    .cnt   (bus.det_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: five parameter variants share one
// stimulus stream; Moore results go through a scoreboard queue.
module tb_seq_detect_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, din, clr;

  seq_detect_param_if #(.CNT_W(8)) i0 ();
  seq_detect_param_if #(.CNT_W(8)) i1 ();
  seq_detect_param_if #(.CNT_W(8)) i2 ();
  seq_detect_param_if #(.CNT_W(2)) i3 ();
  seq_detect_param_if #(.CNT_W(8)) i4 ();

  assign i0.en = en;  assign i0.din = din;  assign i0.clr = clr;
  assign i1.en = en;  assign i1.din = din;  assign i1.clr = clr;
  assign i2.en = en;  assign i2.din = din;  assign i2.clr = clr;
  assign i3.en = en;  assign i3.din = din;  assign i3.clr = clr;
  assign i4.en = en;  assign i4.din = din;  assign i4.clr = clr;

  seq_detect_param dut0 (.clk(clk), .reset(reset), .bus(i0));
  seq_detect_param #(.OVERLAP(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(i1));
  seq_detect_param #(.MOORE(1)) dut2 (.clk(clk), .reset(reset), .bus(i2));
  seq_detect_param #(.CNT_W(2)) dut3 (.clk(clk), .reset(reset), .bus(i3));
  seq_detect_param #(.PAT_LEN(5), .PATTERN(5'b11011)) dut4 (.clk(clk), .reset(reset), .bus(i4));

  wire       det_w [5];
  wire [7:0] cnt_w [5];
  assign det_w[0] = i0.det;  assign cnt_w[0] = i0.det_cnt;
  assign det_w[1] = i1.det;  assign cnt_w[1] = i1.det_cnt;
  assign det_w[2] = i2.det;  assign cnt_w[2] = i2.det_cnt;
  assign det_w[3] = i3.det;  assign cnt_w[3] = {6'd0, i3.det_cnt};
  assign det_w[4] = i4.det;  assign cnt_w[4] = i4.det_cnt;

  // Reference model per variant: pattern, length, overlap, counter maximum.
  int          plen [5] = '{4, 4, 4, 4, 5};
  logic [31:0] ppat [5] = '{32'hA, 32'hA, 32'hA, 32'hA, 32'h1B};
  bit          povl [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  int          pmax [5] = '{255, 255, 255, 3, 255};
  logic [31:0] hm [5];
  int          fm [5];
  int          cm [5];
  bit          mm [5];
  bit          moore_q [$];
  int          n_checks = 0;
  int          n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit e, input bit d, input bit c, input string tag);
    @(negedge clk);
    en = e; din = d; clr = c;
    #1;
    for (int k = 0; k < 5; k++) begin
      logic [32:0] v;
      v = {hm[k], d};
      mm[k] = e && (fm[k] == plen[k] - 1) &&
              ((v & ((33'd1 << plen[k]) - 33'd1)) == {1'b0, ppat[k]});
    end
    for (int k = 0; k < 5; k++) begin
      if (k != 2) check($sformatf("%s mealy_det%0d", tag, k), 32'(det_w[k]), 32'(mm[k]));
    end
    moore_q.push_back(mm[2]);
    @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      if (c) cm[k] = 0;
      else if (mm[k] && cm[k] != pmax[k]) cm[k]++;
      if (e) begin
        if (!povl[k] && mm[k]) fm[k] = 0;
        else if (fm[k] < plen[k] - 1) fm[k]++;
        hm[k] = {hm[k][30:0], d};
      end
    end
    #1;
    check($sformatf("%s moore_det", tag), 32'(det_w[2]), 32'(moore_q.pop_front()));
    for (int k = 0; k < 5; k++) begin
      check($sformatf("%s det_cnt%0d", tag, k), 32'(cnt_w[k]), 32'(cm[k]));
    end
    $display("%s: en=%0b din=%0b clr=%0b det=%0b%0b%0b%0b%0b cnt0=%0d", tag, e, d, c,
             det_w[0], det_w[1], det_w[2], det_w[3], det_w[4], cnt_w[0]);
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0, $sformatf("%s bit%0d", tag, i + 1));
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    reset = 1'b1; en = 1'b0; clr = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      hm[k] = '0; fm[k] = 0; cm[k] = 0;
      check($sformatf("%s reset_det%0d", tag, k), 32'(det_w[k]), 32'd0);
      check($sformatf("%s reset_cnt%0d", tag, k), 32'(cnt_w[k]), 32'd0);
    end
    moore_q.delete();
    $display("%s: reset applied", tag);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; din = 1'b0; clr = 1'b0;
    do_reset("init");

    // Overlap, non-overlap and Moore variants on the same stream.
    send_bits(32'b110101011101010, 15, "t1");
    check("t1 mealy_total", 32'(cnt_w[0]), 32'd4);
    check("t2 nonoverlap_total", 32'(cnt_w[1]), 32'd2);
    check("t3 moore_total", 32'(cnt_w[2]), 32'd4);

    do_reset("t4");
    send_bits(32'b101, 3, "t4");
    step(1'b0, 1'b1, 1'b0, "t4 hold1");
    step(1'b0, 1'b0, 1'b0, "t4 hold2");
    step(1'b0, 1'b1, 1'b0, "t4 hold3");
    step(1'b1, 1'b0, 1'b0, "t4 final");
    check("t4 total", 32'(cnt_w[0]), 32'd1);

    // Reset while a Moore pulse is pending, then reset mid-pattern.
    do_reset("t5");
    send_bits(32'b1010, 4, "t5a");
    do_reset("t5 moore_pending");
    send_bits(32'b101, 3, "t5b");
    do_reset("t5 midstream");
    step(1'b1, 1'b0, 1'b0, "t5 after");
    check("t5 after_total", 32'(cnt_w[0]), 32'd0);
    send_bits(32'b1010, 4, "t5c");
    check("t5 fresh_total", 32'(cnt_w[0]), 32'd1);

    do_reset("t6");
    send_bits(32'b101010101010, 12, "t6");
    check("t6 saturated", 32'(cnt_w[3]), 32'd3);
    check("t6 wide_total", 32'(cnt_w[0]), 32'd5);
    step(1'b1, 1'b1, 1'b0, "t6 pre");
    step(1'b1, 1'b0, 1'b1, "t6 clr_match");
    check("t6 clr_wins0", 32'(cnt_w[0]), 32'd0);
    check("t6 clr_wins3", 32'(cnt_w[3]), 32'd0);

    do_reset("t7");
    send_bits(32'b11011011, 8, "t7");
    check("t7 len5_total", 32'(cnt_w[4]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
